// File: rtl/idex_operand_stage_if.sv
// Signal bundle between decode, forwarding sources and the ID/EX operand stage.
// The master side drives the decode and forwarding fields; the slave side is the stage itself.
interface idex_operand_stage_if;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [3:0]  in_aluop;
   logic [31:0] in_rdat1;
   logic [31:0] in_rdat2;
   logic [15:0] in_imm16;
   logic [4:0]  in_shamt;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_wsel;
   logic [1:0]  in_extop;
   logic        in_alusrc;
   logic        in_regwen;
   logic        exmem_regwen;
   logic [4:0]  exmem_wsel;
   logic [31:0] exmem_res;
   logic        memwb_regwen;
   logic [4:0]  memwb_wsel;
   logic [31:0] memwb_wdat;
   logic        ex_valid;
   logic [3:0]  opcode;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [4:0]  shamt;
   logic [31:0] ex_storedat;
   logic [4:0]  ex_wsel;
   logic        ex_regwen;

   modport master (
      output stall, flush, in_valid, in_aluop, in_rdat1, in_rdat2, in_imm16, in_shamt,
             in_rs, in_rt, in_wsel, in_extop, in_alusrc, in_regwen,
             exmem_regwen, exmem_wsel, exmem_res, memwb_regwen, memwb_wsel, memwb_wdat,
      input  ex_valid, opcode, op1, op2, shamt, ex_storedat, ex_wsel, ex_regwen
   );

   modport slave (
      input  stall, flush, in_valid, in_aluop, in_rdat1, in_rdat2, in_imm16, in_shamt,
             in_rs, in_rt, in_wsel, in_extop, in_alusrc, in_regwen,
             exmem_regwen, exmem_wsel, exmem_res, memwb_regwen, memwb_wsel, memwb_wdat,
      output ex_valid, opcode, op1, op2, shamt, ex_storedat, ex_wsel, ex_regwen
   );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register with immediate extension ahead of the register and
// combinational EX/MEM and MEM/WB operand forwarding behind it.
module idex_operand_stage (
   input  logic           CLK,
   input  logic           RST,
   idex_operand_stage_if.slave bus
);

   typedef struct packed {
      logic        valid;
      logic [3:0]  aluop;
      logic [31:0] rdat1;
      logic [31:0] rdat2;
      logic [31:0] imm_ext;
      logic [4:0]  shamt;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wsel;
      logic        alusrc;
      logic        regwen;
   } stage_t;

   // All-zero is the bubble: invalid, no write, opcode ADD, zero data.
   localparam stage_t BUBBLE = '0;

   stage_t      stage_q;
   stage_t      stage_d;
   logic [31:0] imm_ext;
   logic [31:0] fwd_a;
   logic [31:0] fwd_b;

   always_comb begin
      case (bus.in_extop)
         2'b01:   imm_ext = {{16{bus.in_imm16[15]}}, bus.in_imm16};
         2'b10:   imm_ext = {bus.in_imm16, 16'h0000};
         default: imm_ext = {16'h0000, bus.in_imm16};
      endcase
   end

   always_comb begin
      stage_d         = BUBBLE;
      stage_d.valid   = bus.in_valid;
      stage_d.aluop   = bus.in_aluop;
      stage_d.rdat1   = bus.in_rdat1;
      stage_d.rdat2   = bus.in_rdat2;
      stage_d.imm_ext = imm_ext;
      stage_d.shamt   = bus.in_shamt;
      stage_d.rs      = bus.in_rs;
      stage_d.rt      = bus.in_rt;
      stage_d.wsel    = bus.in_wsel;
      stage_d.alusrc  = bus.in_alusrc;
      stage_d.regwen  = bus.in_regwen & bus.in_valid;
   end

   // Flush outranks stall so a squashed instruction never lingers in EX.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stage_q <= BUBBLE;
      end else if (bus.flush) begin
         stage_q <= BUBBLE;
      end else if (!bus.stall) begin
         stage_q <= stage_d;
      end
   end

   // Younger EX/MEM result wins over MEM/WB; register 0 is never forwarded.
   function automatic logic [31:0] forward (
      input logic [4:0]  rnum,
      input logic [31:0] regval,
      input logic        em_wen,
      input logic [4:0]  em_wsel,
      input logic [31:0] em_res,
      input logic        mw_wen,
      input logic [4:0]  mw_wsel,
      input logic [31:0] mw_wdat
   );
      logic [31:0] result;
      result = regval;
      if (rnum != 5'd0) begin
         if (em_wen && (em_wsel == rnum)) begin
            result = em_res;
         end else if (mw_wen && (mw_wsel == rnum)) begin
            result = mw_wdat;
         end
      end
      return result;
   endfunction

   always_comb begin
      fwd_a = forward(stage_q.rs, stage_q.rdat1,
                      bus.exmem_regwen, bus.exmem_wsel, bus.exmem_res,
                      bus.memwb_regwen, bus.memwb_wsel, bus.memwb_wdat);
      fwd_b = forward(stage_q.rt, stage_q.rdat2,
                      bus.exmem_regwen, bus.exmem_wsel, bus.exmem_res,
                      bus.memwb_regwen, bus.memwb_wsel, bus.memwb_wdat);
   end

   assign bus.op1         = fwd_a;
   assign bus.op2         = stage_q.alusrc ? stage_q.imm_ext : fwd_b;
   assign bus.ex_storedat = fwd_b;
   assign bus.opcode      = stage_q.aluop;
   assign bus.shamt       = stage_q.shamt;
   assign bus.ex_wsel     = stage_q.wsel;
   assign bus.ex_regwen   = stage_q.regwen;
   assign bus.ex_valid    = stage_q.valid;

endmodule
